// File: rtl/cmos_sensor_emulator.sv
// cmos_sensor_emulator: MT9V034-style FVAL/LVAL/DATA source with programmable timing and test patterns.
// Outputs are registered from the next-state decode, so they align with the state they describe.
module cmos_sensor_emulator #(
    parameter int H_ACTIVE   = 752,
    parameter int H_BLANK    = 94,
    parameter int V_ACTIVE   = 480,
    parameter int FV2LV      = 4,
    parameter int LV2FV      = 4,
    parameter int VBLANK_CYC = 1000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iENABLE,
    input  logic [1:0]  iMODE,
    output logic [9:0]  oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [15:0] oFRAME_CNT,
    output logic        oBUSY
);
    typedef enum logic [2:0] {IDLE, FRONT, LINE, HBLANK, BACK, VBLANK} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, frame_q, frame_d;
    logic [9:0]  y_q, y_d, f_q, f_d, x_d, pix_d;
    logic [1:0]  mode_q, mode_d;
    logic        start_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        y_d     = y_q;
        mode_d  = mode_q;
        f_d     = f_q;
        frame_d = frame_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                start_d = iENABLE;
            end
            FRONT: if (cnt_q == 16'(FV2LV - 1)) begin
                state_d = LINE;
                cnt_d   = '0;
            end
            LINE: if (cnt_q == 16'(H_ACTIVE - 1)) begin
                state_d = (y_q == 10'(V_ACTIVE - 1)) ? BACK : HBLANK;
                cnt_d   = '0;
            end
            HBLANK: if (cnt_q == 16'(H_BLANK - 1)) begin
                state_d = LINE;
                cnt_d   = '0;
                y_d     = y_q + 10'd1;
            end
            BACK: if (cnt_q == 16'(LV2FV - 1)) begin
                state_d = VBLANK;
                cnt_d   = '0;
                frame_d = frame_q + 16'd1;
            end
            VBLANK: if (cnt_q == 16'(VBLANK_CYC - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
                start_d = iENABLE;
            end
            default: state_d = IDLE;
        endcase
        // frame_q already holds the incremented count when leaving VBLANK
        if (start_d) begin
            state_d = FRONT;
            cnt_d   = '0;
            y_d     = '0;
            mode_d  = iMODE;
            f_d     = frame_q[9:0];
        end
        x_d   = cnt_d[9:0];
        pix_d = (mode_d == 2'd0) ? x_d + f_d :
                (mode_d == 2'd1) ? {x_d[9:7], x_d[9:7], x_d[9:7], x_d[9]} :
                (mode_d == 2'd2) ? {10{x_d[5] ^ y_d[5]}} : y_d;
    end
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            f_q     <= '0;
            mode_q  <= '0;
            frame_q <= '0;
            oDATA   <= '0;
            oFVAL   <= 1'b0;
            oLVAL   <= 1'b0;
            oBUSY   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            f_q     <= f_d;
            mode_q  <= mode_d;
            frame_q <= frame_d;
            oDATA   <= (state_d == LINE) ? pix_d : 10'd0;
            oFVAL   <= state_d inside {FRONT, LINE, HBLANK, BACK};
            oLVAL   <= state_d == LINE;
            oBUSY   <= state_d != IDLE;
        end
    end
    assign oFRAME_CNT = frame_q;
endmodule

// File: tb/tb_cmos_sensor_emulator.sv
// tb_cmos_sensor_emulator: directed checks of framing, patterns, enable/mode latching and async reset.
module tb_cmos_sensor_emulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0, en2 = 1'b0;
    logic [1:0]  mode = 2'd0, mode2 = 2'd2;
    logic [9:0]  data, data2;
    logic        fval, lval, busy, fval2, lval2, busy2;
    logic [15:0] fcnt, fcnt2;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    cmos_sensor_emulator #(.H_ACTIVE(8), .H_BLANK(3), .V_ACTIVE(4), .FV2LV(2), .LV2FV(2), .VBLANK_CYC(5)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iENABLE(en), .iMODE(mode),
        .oDATA(data), .oFVAL(fval), .oLVAL(lval), .oFRAME_CNT(fcnt), .oBUSY(busy));

    cmos_sensor_emulator #(.H_ACTIVE(128), .H_BLANK(3), .V_ACTIVE(64), .FV2LV(2), .LV2FV(2), .VBLANK_CYC(5)) dut2 (
        .iCLK(clk), .iRST_N(rst_n), .iENABLE(en2), .iMODE(mode2),
        .oDATA(data2), .oFVAL(fval2), .oLVAL(lval2), .oFRAME_CNT(fcnt2), .oBUSY(busy2));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int exp_cnt);
        check({tag, "_fval"}, int'(fval), 0);
        check({tag, "_lval"}, int'(lval), 0);
        check({tag, "_data"}, int'(data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_fcnt"}, int'(fcnt), exp_cnt);
    endtask

    initial begin
        int p, fr, q, ln, px, e_fv, e_lv, e_d, e_fc, found;
        #2 rst_n = 1'b0;
        #1 check_idle("rst0", 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_idle("idle", 0);

        // frame = 2 front + 4*8 active + 3*3 hblank + 2 back (45 FVAL) + 5 vblank = 50
        en = 1'b1;
        tick();
        for (int t = 0; t < 210; t++) begin
            p  = t % 50;
            fr = t / 50;
            q  = p - 2;
            ln = (q >= 0) ? q / 11 : 0;
            px = (q >= 0) ? q % 11 : 0;
            e_fv = (t < 200 && p < 45) ? 1 : 0;
            e_lv = (t < 200 && p >= 2 && p < 43 && px < 8) ? 1 : 0;
            e_d  = !e_lv ? 0 : (fr < 2) ? ((px + fr) & 10'h3FF) : ln;
            e_fc = (t >= 200) ? 4 : fr + ((p >= 45) ? 1 : 0);
            check($sformatf("fval_t%0d", t), int'(fval), e_fv);
            check($sformatf("lval_t%0d", t), int'(lval), e_lv);
            check($sformatf("data_t%0d", t), int'(data), e_d);
            check($sformatf("fcnt_t%0d", t), int'(fcnt), e_fc);
            check($sformatf("busy_t%0d", t), int'(busy), (t < 200) ? 1 : 0);
            if (t == 70)  mode = 2'd3;
            if (t == 165) en = 1'b0;
            tick();
        end

        en = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (lval) found = 1;
            else tick();
        end
        check("lval_wait", found, 1);
        check("pre_rst_fcnt", int'(fcnt), 4);
        #2 rst_n = 1'b0;
        #1 check_idle("rst_mid", 0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_idle("post_rst", 0);

        en2 = 1'b1;
        tick();
        for (int t = 0; t <= 4226; t++) begin
            if (t == 2)    begin check("chk_x0y0_lv", int'(lval2), 1);  check("chk_x0y0", int'(data2), 10'h000); end
            if (t == 34)   begin check("chk_x32y0_lv", int'(lval2), 1); check("chk_x32y0", int'(data2), 10'h3FF); end
            if (t == 4194) begin check("chk_x0y32", int'(data2), 10'h3FF); end
            if (t == 4226) begin check("chk_x32y32_lv", int'(lval2), 1); check("chk_x32y32", int'(data2), 10'h000); end
            tick();
        end
        en2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
